udp_rx_main: RTL and testbench



---
 rtl/udp_rx_pkg.sv | 25 ++
 rtl/udp_rx_main_if.sv | 12 +
 rtl/udp_rx_main_sfd_detect.sv | 30 +++
 rtl/udp_rx_main.sv | 159 +++++++++++++++
 tb/tb_udp_rx_main.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/udp_rx_pkg.sv
// Shared types and protocol constants for the byte-serial Ethernet/IPv4/UDP
// receive classifier.
package udp_rx_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    MAC     = 3'd1,
    ETYPE   = 3'd2,
    IP_HDR  = 3'd3,
    UDP_HDR = 3'd4,
    PAYLOAD = 3'd5,
    SKIP    = 3'd6
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [2:0]  PREAMBLE_MIN   = 3'd7;
  localparam logic [15:0] MAC_BYTES      = 16'd12;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IP_VERSION     = 4'd4;
  localparam logic [3:0]  IP_IHL_MIN     = 4'd5;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] UDP_HDR_BYTES  = 16'd8;

endpackage

// File: rtl/udp_rx_main_if.sv
// Byte interface between the MAC/PHY side and the receive classifier.
// Strobe semantics: eth_byte is consumed on every rising edge where input_ready=1;
// there is no ready/backpressure, so the source may never be stalled.
interface udp_rx_main_if;
  logic [7:0] eth_byte;
  logic       input_ready;
  logic       valid_ip;
  logic       valid_udp;

  modport master (output eth_byte, output input_ready, input valid_ip, input valid_udp);
  modport slave  (input eth_byte, input input_ready, output valid_ip, output valid_udp);
endinterface

// File: rtl/udp_rx_main_sfd_detect.sv
// Preamble/SFD matcher: counts consecutive 0x55 octets (saturating) and flags
// a 0xD5 that follows at least PREAMBLE_MIN of them.
module eth_sfd_detect
  import udp_rx_pkg::*;
(
  input  logic       main_clk,
  input  logic       main_rst,
  input  logic       en,
  input  logic [7:0] data,
  output logic       sfd_hit
);

  logic [2:0] count_q;

  assign sfd_hit = en && (data == SFD_BYTE) && (count_q >= PREAMBLE_MIN);

  // Any non-0x55 byte (including an SFD, hit or not) restarts the count.
  always_ff @(posedge main_clk) begin
    if (!main_rst) begin
      count_q <= 3'd0;
    end else if (en) begin
      if (data == PREAMBLE_BYTE) begin
        count_q <= (count_q == 3'd7) ? 3'd7 : count_q + 3'd1;
      end else begin
        count_q <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/udp_rx_main.sv
// Receive classifier FSM: walks preamble, Ethernet II and IPv4 headers and
// raises valid_ip / valid_udp, holding them until the next accepted SFD.
module udp_rx_main
  import udp_rx_pkg::*;
(
  input  logic         main_clk,
  input  logic         main_rst,
  udp_rx_main_if.slave rx,
  output state_t       state
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] total_len_q, total_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  etype_hi_q, etype_hi_d;
  logic        valid_ip_q, valid_ip_d;
  logic        valid_udp_q, valid_udp_d;
  logic        sfd_hit;

  logic [5:0]  ihl_x4;
  logic [15:0] hdr_len;
  logic [15:0] ip_body;
  logic [15:0] udp_payload;

  assign ihl_x4      = {ihl_q, 2'b00};
  assign hdr_len     = {10'd0, ihl_x4};
  assign ip_body     = total_len_q - hdr_len;
  assign udp_payload = ip_body - UDP_HDR_BYTES;

  assign state        = state_q;
  assign rx.valid_ip  = valid_ip_q;
  assign rx.valid_udp = valid_udp_q;

  eth_sfd_detect u_sfd (
    .main_clk (main_clk),
    .main_rst (main_rst),
    .en       (rx.input_ready && (state_q == HUNT)),
    .data     (rx.eth_byte),
    .sfd_hit  (sfd_hit)
  );

  always_ff @(posedge main_clk) begin
    if (!main_rst) begin
      state_q     <= HUNT;
      cnt_q       <= 16'd0;
      total_len_q <= 16'd0;
      proto_q     <= 8'd0;
      ihl_q       <= 4'd0;
      etype_hi_q  <= 8'd0;
      valid_ip_q  <= 1'b0;
      valid_udp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_len_q <= total_len_d;
      proto_q     <= proto_d;
      ihl_q       <= ihl_d;
      etype_hi_q  <= etype_hi_d;
      valid_ip_q  <= valid_ip_d;
      valid_udp_q <= valid_udp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    total_len_d = total_len_q;
    proto_d     = proto_q;
    ihl_d       = ihl_q;
    etype_hi_d  = etype_hi_q;
    valid_ip_d  = valid_ip_q;
    valid_udp_d = valid_udp_q;

    if (rx.input_ready) begin
      unique case (state_q)
        HUNT: begin
          if (sfd_hit) begin
            valid_ip_d  = 1'b0;
            valid_udp_d = 1'b0;
            state_d     = MAC;
            cnt_d       = 16'd0;
          end
        end
        MAC: begin
          if (cnt_q == MAC_BYTES - 16'd1) begin
            state_d = ETYPE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ETYPE: begin
          if (cnt_q == 16'd0) begin
            etype_hi_d = rx.eth_byte;
            cnt_d      = 16'd1;
          end else begin
            cnt_d   = 16'd0;
            state_d = ({etype_hi_q, rx.eth_byte} == ETHERTYPE_IPV4) ? IP_HDR : HUNT;
          end
        end
        IP_HDR: begin
          if (cnt_q == 16'd0) begin
            if (rx.eth_byte[7:4] == IP_VERSION && rx.eth_byte[3:0] >= IP_IHL_MIN) begin
              valid_ip_d = 1'b1;
              ihl_d      = rx.eth_byte[3:0];
              cnt_d      = 16'd1;
            end else begin
              state_d = HUNT;
            end
          end else begin
            if (cnt_q == 16'd2) total_len_d[15:8] = rx.eth_byte;
            if (cnt_q == 16'd3) total_len_d[7:0]  = rx.eth_byte;
            if (cnt_q == 16'd9) proto_d           = rx.eth_byte;
            // IHL >= 5 means the last header byte is at least byte 19, so the
            // captured length and protocol are already registered here.
            if (cnt_q == hdr_len - 16'd1) begin
              if (proto_q == IP_PROTO_UDP && total_len_q >= hdr_len + UDP_HDR_BYTES) begin
                state_d = UDP_HDR;
                cnt_d   = 16'd0;
              end else if (total_len_q <= hdr_len) begin
                state_d = HUNT;
                cnt_d   = 16'd0;
              end else begin
                state_d = SKIP;
                cnt_d   = ip_body;
              end
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        UDP_HDR: begin
          if (cnt_q == UDP_HDR_BYTES - 16'd1) begin
            valid_udp_d = 1'b1;
            state_d     = (udp_payload == 16'd0) ? HUNT : PAYLOAD;
            cnt_d       = udp_payload;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        PAYLOAD, SKIP: begin
          if (cnt_q <= 16'd1) begin
            state_d = HUNT;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_main.sv
// Directed bench for udp_rx_main: a table of whole frames with hand-computed
// flag results, plus hand-written sequences for latency, reset and SFD corners.
module tb_udp_rx_main;
  import udp_rx_pkg::*;

  // ---------------- clock / reset ----------------
  logic   main_clk;
  logic   main_rst;
  state_t dbg_state;

  udp_rx_main_if rx_if ();

  udp_rx_main dut (
    .main_clk (main_clk),
    .main_rst (main_rst),
    .rx       (rx_if.slave),
    .state    (dbg_state)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input bit e_ip, input bit e_udp, input state_t e_st);
    check({name, ".valid_ip"},  32'(rx_if.valid_ip),  32'(e_ip));
    check({name, ".valid_udp"}, 32'(rx_if.valid_udp), 32'(e_udp));
    check({name, ".state"},     32'(dbg_state),       32'(e_st));
  endtask

  // ---------------- drivers ----------------
  // Called on a falling edge; returns on the falling edge after the accepting edge
  // (one extra idle cycle when gap=1).
  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_if.eth_byte    = b;
    rx_if.input_ready = 1'b1;
    @(negedge main_clk);
    rx_if.input_ready = 1'b0;
    if (gap) @(negedge main_clk);
  endtask

  task automatic send_sync(input int n55, input bit gap);
    for (int i = 0; i < n55; i++) send_byte(8'h55, gap);
    send_byte(8'hD5, gap);
  endtask

  task automatic send_mac(input bit gap);
    for (int i = 0; i < 12; i++) send_byte(8'(8'hA0 + i), gap);
  endtask

  function automatic logic [7:0] ip_byte(input int i, input logic [7:0] ip0,
                                         input logic [15:0] tl, input logic [7:0] proto);
    case (i)
      0:       return ip0;
      2:       return tl[15:8];
      3:       return tl[7:0];
      9:       return proto;
      default: return 8'h00;
    endcase
  endfunction

  // Full frame; 'hold' bytes are withheld from the end of the IP body.
  task automatic send_frame(input logic [15:0] etype, input logic [7:0] ip0,
                            input logic [15:0] tl, input logic [7:0] proto,
                            input bit gap, input int hold);
    int hdr;
    int body;
    send_sync(7, gap);
    send_mac(gap);
    send_byte(etype[15:8], gap);
    send_byte(etype[7:0], gap);
    if (etype == 16'h0800) begin
      hdr = int'(ip0[3:0]) * 4;
      for (int i = 0; i < hdr; i++) send_byte(ip_byte(i, ip0, tl, proto), gap);
      body = (int'(tl) > hdr) ? int'(tl) - hdr : 0;
      for (int i = 0; i < body - hold; i++) send_byte(8'h00, gap);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] etype;
    logic [7:0]  ip0;
    logic [15:0] tl;
    logic [7:0]  proto;
    bit          gap;
    bit          exp_ip;
    bit          exp_udp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{16'h0800, 8'h45, 16'd28,  8'h11, 1'b0, 1'b1, 1'b1}; // UDP, no payload
    vecs[1] = '{16'h86DD, 8'h45, 16'd28,  8'h11, 1'b1, 1'b0, 1'b0}; // IPv6 ethertype
    vecs[2] = '{16'h0800, 8'h65, 16'd28,  8'h11, 1'b0, 1'b0, 1'b0}; // version 6
    vecs[3] = '{16'h0800, 8'h44, 16'd28,  8'h11, 1'b1, 1'b0, 1'b0}; // IHL 4
    vecs[4] = '{16'h0800, 8'h45, 16'd28,  8'h11, 1'b1, 1'b1, 1'b1}; // recovery after bad frames
    vecs[5] = '{16'h0800, 8'h46, 16'd60,  8'h06, 1'b0, 1'b1, 1'b0}; // TCP with options, SKIP 36
    vecs[6] = '{16'h0800, 8'h45, 16'd100, 8'h11, 1'b0, 1'b1, 1'b1}; // UDP with 72-byte payload
    vecs[7] = '{16'h0800, 8'h45, 16'd20,  8'h11, 1'b0, 1'b1, 1'b0}; // no room for UDP header
    vecs[8] = '{16'h0800, 8'h45, 16'd26,  8'h11, 1'b1, 1'b1, 1'b0}; // short UDP, SKIP 6
  end

  // ---------------- test sequence ----------------
  initial begin
    main_rst          = 1'b0;
    rx_if.eth_byte    = 8'h00;
    rx_if.input_ready = 1'b0;
    repeat (3) @(negedge main_clk);
    check_all("reset", 1'b0, 1'b0, HUNT);
    main_rst = 1'b1;
    @(negedge main_clk);

    // valid_ip latency with a 1-on/1-off strobe, then the rest of a UDP frame.
    send_sync(7, 1'b1);
    send_mac(1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    check("pre_ip.valid_ip", 32'(rx_if.valid_ip), 32'd0);
    send_byte(8'h45, 1'b0);
    check_all("ip_latency", 1'b1, 1'b0, IP_HDR);
    for (int i = 1; i < 20; i++) send_byte(ip_byte(i, 8'h45, 16'h001C, 8'h11), 1'b1);
    check_all("ip_end", 1'b1, 1'b0, UDP_HDR);
    for (int i = 0; i < 7; i++) send_byte(8'h00, 1'b1);
    check_all("udp_7th", 1'b1, 1'b0, UDP_HDR);
    send_byte(8'h00, 1'b0);
    check_all("udp_8th", 1'b1, 1'b1, HUNT);
    send_sync(7, 1'b0);
    check_all("sfd_clears", 1'b0, 1'b0, MAC);
    send_mac(1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    check_all("etype_1234", 1'b0, 1'b0, HUNT);

    // Reset with the strobe held high in the middle of the UDP header.
    send_frame(16'h0800, 8'h45, 16'd28, 8'h11, 1'b0, 5);
    check_all("mid_udp", 1'b1, 1'b0, UDP_HDR);
    main_rst          = 1'b0;
    rx_if.eth_byte    = 8'h00;
    rx_if.input_ready = 1'b1;
    @(negedge main_clk);
    main_rst          = 1'b1;
    rx_if.input_ready = 1'b0;
    check_all("rst_mid", 1'b0, 1'b0, HUNT);
    for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0);
    check_all("rst_tail", 1'b0, 1'b0, HUNT);

    // Preamble corner cases.
    send_sync(6, 1'b0);
    check_all("pre_6", 1'b0, 1'b0, HUNT);
    for (int i = 0; i < 3; i++) send_byte(8'h55, 1'b0);
    send_byte(8'h00, 1'b0);
    send_sync(4, 1'b0);
    check_all("pre_stray", 1'b0, 1'b0, HUNT);
    send_sync(8, 1'b1);
    check_all("pre_8", 1'b0, 1'b0, MAC);
    send_mac(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check_all("pre_8_done", 1'b0, 1'b0, HUNT);

    // Table of whole frames.
    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].etype, vecs[v].ip0, vecs[v].tl, vecs[v].proto, vecs[v].gap, 0);
      check_all($sformatf("vec%0d", v), vecs[v].exp_ip, vecs[v].exp_udp, HUNT);
    end

    // SKIP must consume exactly total_length - 24 bytes for IHL=6.
    send_frame(16'h0800, 8'h46, 16'd60, 8'h06, 1'b1, 1);
    check_all("skip_last_pending", 1'b1, 1'b0, SKIP);
    send_byte(8'h00, 1'b0);
    check_all("skip_done", 1'b1, 1'b0, HUNT);
    send_frame(16'h0800, 8'h45, 16'd28, 8'h11, 1'b0, 0);
    check_all("after_skip", 1'b1, 1'b1, HUNT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
